mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle successor to the single-cycle main decoder.
- Sequences each MIPS instruction through fetch, decode, execute, memory and writeback states, driving datapath mux and enable strobes.
- Adds a memory ready/wait handshake, an optional bus-timeout counter and illegal-opcode detection.
- Sits between the instruction register opcode field and the shared multi-cycle datapath (PC, IR, MDR, A/B, ALUOut).

Parameters:
- OPCODE_W, 6, width of opcode input.
- ALUOP_W, 2, width of alu_op output (must be >=2; upper bits are 0).
- MEM_TIMEOUT, 0, max consecutive wait cycles per memory access before bus_err; 0 disables the counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  OPCODE_W  IR[31:26]
- mem_ready  in  1  memory completes the access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  load IR
- mem_to_reg  out  1  writeback source is MDR
- reg_dst  out  1  writeback register is rd (else rt)
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign/zero-ext imm, 11 ext imm<<2
- alu_op  out  ALUOP_W  00 add, 01 sub, 10 R-funct, 11 imm-logic (ALU control decodes opcode)
- zero_ext  out  1  immediate zero-extended (andi/ori)
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
- illegal_op  out  1  one-cycle pulse on unknown opcode
- bus_err  out  1  one-cycle pulse on memory timeout
- state_o  out  4  current state (debug)

Behaviour:
- Reset: state = FETCH; wait counter = 0; all strobes 0; state_o = FETCH encoding.
- Outputs are Moore-decoded from state, except strobes gated by mem_ready, which are qualified combinationally in the same cycle.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write asserted only in the cycle mem_ready=1; then go to DECODE.
  - Otherwise hold FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011/101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 001000/001100/001101 -> I_EXEC
  - any other -> FETCH with illegal_op=1 for that cycle
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1; hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; hold until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- I_EXEC:
  - alu_src_a=1, alu_src_b=10.
  - alu_op=00 for addi, 11 for andi/ori.
  - zero_ext=1 for andi/ori.
  - -> I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- Opcode usage: sampled combinationally in DECODE, MEM_ADDR and I_EXEC; the IR is stable after FETCH.
- Wait counter (MEM_TIMEOUT>0):
  - Counts cycles spent in FETCH, MEM_READ or MEM_WRITE with mem_ready=0; clears on state exit.
  - On reaching MEM_TIMEOUT with mem_ready still 0: bus_err=1 for that cycle; strobes drop; next state FETCH. PC is not advanced.
  - mem_ready=1 in the same cycle as the timeout wins: normal completion, no bus_err.
- mem_ready outside memory states is ignored.
- Reset asserted mid-instruction returns to FETCH next edge; no register or memory write strobes in that cycle.
- Unused state encodings -> FETCH.

Optional Feature:
- MC_JUMP_EN defined:
  - Opcode 000010 decodes in DECODE to JUMP.
  - JUMP: pc_write=1, pc_source=10 -> FETCH.
- Undefined: 000010 is illegal (illegal_op pulse); pc_source never 10.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum encodings (4-bit)
  - opcode constants (OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J)
  - alu_op, alu_src_b and pc_source encodings
- Sub-module mc_mem_wait_ctr: the timeout counter, with enable, clear and expire; tied off when MEM_TIMEOUT=0.

Test Plan:
- lw (100011), mem_ready always 1 -> FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, FETCH; 5 cycles; reg_write and mem_to_reg both high only in MEM_WB.
- sw with mem_ready low 3 cycles in MEM_WRITE -> mem_write held 4 cycles; reg_write never asserted; 7 cycles total.
- ori (001101) -> I_EXEC shows alu_op=11, zero_ext=1, alu_src_b=10; I_WB reg_write=1, reg_dst=0.
- Opcode 111111 -> illegal_op pulse in the DECODE cycle; next state FETCH; no write strobes.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> bus_err on the 4th wait cycle; ir_write and pc_write never asserted; returns to FETCH.
- Reset asserted in R_EXEC -> next edge state_o=FETCH; reg_write stays 0. With MC_JUMP_EN, opcode 000010 -> JUMP with pc_write=1, pc_source=10.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Brief    : State encodings, opcode constants and datapath mux encodings
//            shared by the multi-cycle MIPS control FSM.
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // Controller states (4-bit debug encoding exported on state_o)
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU operation class handed to the ALU control decoder
    localparam logic [1:0] c_aluop_add      = 2'b00;
    localparam logic [1:0] c_aluop_sub      = 2'b01;
    localparam logic [1:0] c_aluop_rfunct   = 2'b10;
    localparam logic [1:0] c_aluop_immlogic = 2'b11;

    // ALU B-operand select
    localparam logic [1:0] c_srcb_b       = 2'b00;
    localparam logic [1:0] c_srcb_four    = 2'b01;
    localparam logic [1:0] c_srcb_imm     = 2'b10;
    localparam logic [1:0] c_srcb_imm_sh2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    // States that own a memory access and may stall on mem_ready
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_mem_wait_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mc_mem_wait_ctr
// Brief    : Counts consecutive memory wait cycles and flags the cycle in
//            which the TIMEOUT-th wait occurs.
// Revision : 1.0 - initial release
// ============================================================================
module mc_mem_wait_ctr #(
    parameter int TIMEOUT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_last = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // The current wait cycle is the TIMEOUT-th one when the count already
    // holds TIMEOUT-1 earlier waits.
    assign expire = en && (r_cnt == c_last);

    // Wait-cycle counter; restarts on exit, on timeout and on reset
    always_ff @(posedge clk) begin
        if (reset || clr || expire) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Brief    : Multi-cycle MIPS control FSM. Steps each instruction through
//            fetch/decode/execute/memory/writeback, with memory ready/wait
//            handshake, optional bus timeout and illegal-opcode detection.
//            Build option: define MC_JUMP_EN to decode opcode 000010 (j).
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                zero_ext,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic                bus_err,
    output logic [3:0]          state_o
);

    localparam logic [OPCODE_W-1:0] c_op_rtype = OPCODE_W'(OP_RTYPE);
    localparam logic [OPCODE_W-1:0] c_op_beq   = OPCODE_W'(OP_BEQ);
    localparam logic [OPCODE_W-1:0] c_op_addi  = OPCODE_W'(OP_ADDI);
    localparam logic [OPCODE_W-1:0] c_op_andi  = OPCODE_W'(OP_ANDI);
    localparam logic [OPCODE_W-1:0] c_op_ori   = OPCODE_W'(OP_ORI);
    localparam logic [OPCODE_W-1:0] c_op_lw    = OPCODE_W'(OP_LW);
    localparam logic [OPCODE_W-1:0] c_op_sw    = OPCODE_W'(OP_SW);
`ifdef MC_JUMP_EN
    localparam logic [OPCODE_W-1:0] c_op_j     = OPCODE_W'(OP_J);
`endif

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_alu_op;
    logic       w_wait;
    logic       w_clr;
    logic       w_expire;

    // A stall cycle is a memory-owning state whose access has not completed
    assign w_wait  = is_mem_state(r_state) && !mem_ready && !reset;
    assign w_clr   = !w_wait;
    assign state_o = r_state;
    assign alu_op  = ALUOP_W'(w_alu_op);

    generate
        if (MEM_TIMEOUT > 0) begin : g_wait_ctr
            mc_mem_wait_ctr #(
                .TIMEOUT (MEM_TIMEOUT)
            ) u_wait_ctr (
                .clk    (clk),
                .reset  (reset),
                .en     (w_wait),
                .clr    (w_clr),
                .expire (w_expire)
            );
        end else begin : g_no_wait_ctr
            logic w_unused_wait;
            assign w_unused_wait = w_wait ^ w_clr;
            assign w_expire      = 1'b0;
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs; memory completion/timeout qualify strobes
    always_comb begin
        w_next        = r_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = c_srcb_b;
        w_alu_op      = c_aluop_add;
        zero_ext      = 1'b0;
        pc_source     = c_pcsrc_alu;
        illegal_op    = 1'b0;
        bus_err       = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = c_srcb_four;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_expire) begin
                    mem_read = 1'b0;
                    bus_err  = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut
                alu_src_b = c_srcb_imm_sh2;
                case (opcode)
                    c_op_rtype:          w_next = S_R_EXEC;
                    c_op_lw, c_op_sw:    w_next = S_MEM_ADDR;
                    c_op_beq:            w_next = S_BRANCH;
                    c_op_addi, c_op_andi,
                    c_op_ori:            w_next = S_I_EXEC;
`ifdef MC_JUMP_EN
                    c_op_j:              w_next = S_JUMP;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = c_srcb_imm;
                if (opcode == c_op_lw) begin
                    w_next = S_MEM_READ;
                end else if (opcode == c_op_sw) begin
                    w_next = S_MEM_WRITE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end else if (w_expire) begin
                    mem_read = 1'b0;
                    bus_err  = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_expire) begin
                    mem_write = 1'b0;
                    bus_err   = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                w_alu_op  = c_aluop_rfunct;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                w_alu_op      = c_aluop_sub;
                pc_write_cond = 1'b1;
                pc_source     = c_pcsrc_aluout;
                w_next        = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = c_srcb_imm;
                if ((opcode == c_op_andi) || (opcode == c_op_ori)) begin
                    w_alu_op = c_aluop_immlogic;
                    zero_ext = 1'b1;
                end
                w_next = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = c_pcsrc_jump;
                w_next    = S_FETCH;
            end
`endif
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Nothing is driven to the datapath while reset is held
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = c_srcb_b;
            w_alu_op      = c_aluop_add;
            zero_ext      = 1'b0;
            pc_source     = c_pcsrc_alu;
            illegal_op    = 1'b0;
            bus_err       = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_fsm
// Brief    : Directed, table-driven self-checking bench for mc_control_fsm
//            built with MEM_TIMEOUT=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, zero_ext;
    logic       illegal_op, bus_err;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    mc_control_fsm #(
        .OPCODE_W    (6),
        .ALUOP_W     (2),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .zero_ext      (zero_ext),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .bus_err       (bus_err),
        .state_o       (state_o)
    );

    // Output bundle: pw pwc iod mr mw _ irw m2r rd rw asa _ srcb _ aluop _ zx _ pcsrc _ ill berr
    wire [18:0] outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                        ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                        alu_src_b, alu_op, zero_ext, pc_source, illegal_op, bus_err};

    localparam logic [18:0] E_ZERO       = 19'b00000_00000_00_00_0_00_00;
    localparam logic [18:0] E_FETCH_WAIT = 19'b00010_00000_01_00_0_00_00;
    localparam logic [18:0] E_FETCH_GO   = 19'b10010_10000_01_00_0_00_00;
    localparam logic [18:0] E_FETCH_TO   = 19'b00000_00000_01_00_0_00_01;
    localparam logic [18:0] E_DECODE     = 19'b00000_00000_11_00_0_00_00;
    localparam logic [18:0] E_DEC_ILL    = 19'b00000_00000_11_00_0_00_10;
    localparam logic [18:0] E_ADDR       = 19'b00000_00001_10_00_0_00_00;
    localparam logic [18:0] E_MREAD      = 19'b00110_00000_00_00_0_00_00;
    localparam logic [18:0] E_MREAD_TO   = 19'b00100_00000_00_00_0_00_01;
    localparam logic [18:0] E_MWB        = 19'b00000_01010_00_00_0_00_00;
    localparam logic [18:0] E_MWRITE     = 19'b00101_00000_00_00_0_00_00;
    localparam logic [18:0] E_REXEC      = 19'b00000_00001_00_10_0_00_00;
    localparam logic [18:0] E_RWB        = 19'b00000_00110_00_00_0_00_00;
    localparam logic [18:0] E_BRANCH     = 19'b01000_00001_00_01_0_01_00;
    localparam logic [18:0] E_ILOGIC     = 19'b00000_00001_10_11_1_00_00;
    localparam logic [18:0] E_IWB        = 19'b00000_00010_00_00_0_00_00;
`ifdef MC_JUMP_EN
    localparam logic [18:0] E_JUMP       = 19'b10000_00000_00_00_0_10_00;
`endif

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  opc;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] exp;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic rst, input logic [5:0] opc, input logic rdy,
                       input state_t st, input logic [18:0] exp);
        vec_t v;
        v.rst = rst; v.opc = opc; v.rdy = rdy; v.st = st; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check before the edge, then advance a cycle
    task automatic apply(input string tag, input int idx, input logic rst,
                         input logic [5:0] opc, input logic rdy,
                         input logic [3:0] st, input logic [18:0] exp);
        reset     = rst;
        opcode    = opc;
        mem_ready = rdy;
        #1;
        chk({tag, "_state"}, idx, 32'(state_o), 32'(st));
        chk({tag, "_outs"},  idx, 32'(outs),    32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] opc);
        add(0, opc, 1, S_FETCH,  E_FETCH_GO);
        add(0, opc, 0, S_DECODE, E_DECODE);
    endtask

    initial begin
        // Reset hold
        add(1, LW, 0, S_FETCH, E_ZERO);
        // lw, memory always ready: 5 cycles
        instr(LW);
        add(0, LW, 1, S_MEM_ADDR, E_ADDR);
        add(0, LW, 1, S_MEM_READ, E_MREAD);
        add(0, LW, 1, S_MEM_WB,   E_MWB);
        // sw with 3 wait cycles in MEM_WRITE: 7 cycles
        instr(SW);
        add(0, SW, 0, S_MEM_ADDR,  E_ADDR);
        add(0, SW, 0, S_MEM_WRITE, E_MWRITE);
        add(0, SW, 0, S_MEM_WRITE, E_MWRITE);
        add(0, SW, 0, S_MEM_WRITE, E_MWRITE);
        add(0, SW, 1, S_MEM_WRITE, E_MWRITE);
        // R-type
        instr(RT);
        add(0, RT, 1, S_R_EXEC, E_REXEC);
        add(0, RT, 0, S_R_WB,   E_RWB);
        // beq
        instr(BEQ);
        add(0, BEQ, 1, S_BRANCH, E_BRANCH);
        // addi / ori / andi
        instr(ADDI);
        add(0, ADDI, 0, S_I_EXEC, E_ADDR);
        add(0, ADDI, 0, S_I_WB,   E_IWB);
        instr(ORI);
        add(0, ORI, 1, S_I_EXEC, E_ILOGIC);
        add(0, ORI, 0, S_I_WB,   E_IWB);
        instr(ANDI);
        add(0, ANDI, 0, S_I_EXEC, E_ILOGIC);
        add(0, ANDI, 1, S_I_WB,   E_IWB);
        // Illegal opcode
        add(0, BAD, 1, S_FETCH,  E_FETCH_GO);
        add(0, BAD, 0, S_DECODE, E_DEC_ILL);
        // Jump opcode
        add(0, JMP, 1, S_FETCH,  E_FETCH_GO);
`ifdef MC_JUMP_EN
        add(0, JMP, 0, S_DECODE, E_DECODE);
        add(0, JMP, 0, S_JUMP,   E_JUMP);
`else
        add(0, JMP, 0, S_DECODE, E_DEC_ILL);
`endif
        // Fetch timeout on 4th wait, then ready wins on the next 4th cycle
        for (int i = 0; i < 3; i++) add(0, RT, 0, S_FETCH, E_FETCH_WAIT);
        add(0, RT, 0, S_FETCH, E_FETCH_TO);
        for (int i = 0; i < 3; i++) add(0, RT, 0, S_FETCH, E_FETCH_WAIT);
        add(0, RT, 1, S_FETCH,  E_FETCH_GO);
        add(0, RT, 0, S_DECODE, E_DECODE);
        // Reset in R_EXEC: no strobes, back to FETCH
        add(1, RT, 1, S_R_EXEC, E_ZERO);
        add(0, RT, 0, S_FETCH,  E_FETCH_WAIT);
        add(0, RT, 1, S_FETCH,  E_FETCH_GO);
        add(0, RT, 0, S_DECODE, E_DECODE);
        add(0, RT, 0, S_R_EXEC, E_REXEC);
        add(0, RT, 0, S_R_WB,   E_RWB);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            apply("vec", i, vq[i].rst, vq[i].opc, vq[i].rdy, vq[i].st, vq[i].exp);
        end

        // lw whose data read times out: bus_err, read strobe dropped
        apply("lwto", 0, 0, LW, 1, S_FETCH,    E_FETCH_GO);
        apply("lwto", 1, 0, LW, 1, S_DECODE,   E_DECODE);
        apply("lwto", 2, 0, LW, 0, S_MEM_ADDR, E_ADDR);
        apply("lwto", 3, 0, LW, 0, S_MEM_READ, E_MREAD);
        apply("lwto", 4, 0, LW, 0, S_MEM_READ, E_MREAD);
        apply("lwto", 5, 0, LW, 0, S_MEM_READ, E_MREAD);
        apply("lwto", 6, 0, LW, 0, S_MEM_READ, E_MREAD_TO);
        apply("lwto", 7, 0, LW, 1, S_FETCH,    E_FETCH_GO);
        apply("lwto", 8, 0, SW, 0, S_DECODE,   E_DECODE);

        // sw with reset landing on a completing write: no write strobe
        apply("swrst", 0, 0, SW, 0, S_MEM_ADDR,  E_ADDR);
        apply("swrst", 1, 0, SW, 0, S_MEM_WRITE, E_MWRITE);
        apply("swrst", 2, 1, SW, 1, S_MEM_WRITE, E_ZERO);
        apply("swrst", 3, 0, SW, 0, S_FETCH,     E_FETCH_WAIT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
